dco_tune_ctrl: RTL and testbench
================================

DCO_TUNE_CTRL -- requirements
Module: dco_tune_ctrl

Interface
REQ-001 Parameter COARSE_W, default 6: width of the coarse capacitor-bank code.
REQ-002 Parameter FINE_W, default 8: width of the fine capacitor-bank code.
REQ-003 Parameter ERR_W, default 16: width of the signed frequency error.
REQ-004 Parameter SETTLE_CYC, default 8: ref_clk cycles to wait after any code change before a measurement starts.
REQ-005 Parameter LOCK_TOL, default 2: in-band error magnitude limit, inclusive.
REQ-006 Parameter UNLOCK_TOL, default 8: error magnitude that drops lock, exclusive.
REQ-007 Parameter LOCK_CNT, default 4: number of consecutive in-band measurements required to declare lock.
REQ-008 Parameter TIMEOUT_CYC, default 1024: maximum cycles to wait for meas_valid.
REQ-009 Clock and reset are decided as follows: one clock; reset is asynchronous and active-high.
REQ-010 ref_clk  in  1  sole clock.
REQ-011 reset  in  1  asynchronous reset, active-high.
REQ-012 enable  in  1  level; 1 = run tuning, 0 = abort to IDLE.
REQ-013 meas_start  out  1  one-cycle pulse that requests one frequency measurement.
REQ-014 meas_valid  in  1  one-cycle pulse qualifying meas_err.
REQ-015 meas_err  in  ERR_W  signed, dco_cnt minus target; positive means the DCO is too fast.
REQ-016 sw_coarse  out  COARSE_W  coarse code to the DCO.
REQ-017 sw_fine  out  FINE_W  fine code to the DCO.
REQ-018 locked  out  1  lock indication.
REQ-019 busy  out  1  high whenever the state is not IDLE.
REQ-020 fine_sat  out  1  sticky flag: the fine code was clamped at 0 or at its maximum.
REQ-021 timeout_err  out  1  sticky flag: a measurement timed out.

Function
REQ-022 The controller SHALL have exactly these states: IDLE, SETTLE, MEAS, COARSE_UPD, FINE_TRACK, LOCKED.
REQ-023 A higher code SHALL mean more capacitance and lower frequency, so a positive error SHALL move the code upward.
REQ-024 In IDLE with enable=1, the controller SHALL load sw_coarse=1<<(COARSE_W-1), set sw_fine=1<<(FINE_W-1), set the bit pointer to MSB, and enter SETTLE on the next cycle.
REQ-025 SETTLE SHALL count SETTLE_CYC cycles, then pulse meas_start for 1 cycle and enter MEAS.
REQ-026 MEAS SHALL wait for meas_valid; any meas_valid outside MEAS SHALL be ignored.
REQ-027 If TIMEOUT_CYC cycles pass in MEAS without meas_valid, the controller SHALL set timeout_err, clear locked, and return to IDLE.
REQ-028 Coarse successive approximation, applied to the current bit on meas_valid: err<0 clears the bit; err>=0 keeps it; then the next lower bit is set, followed by SETTLE.
REQ-029 After the LSB decision, coarse SHALL be frozen and the controller SHALL go to SETTLE, then to FINE_TRACK measurements.
REQ-030 FINE_TRACK step rule: err>LOCK_TOL means fine+1; err<-LOCK_TOL means fine-1; otherwise no change and the in-band counter increments.
REQ-031 Any out-of-band measurement SHALL clear the in-band counter.
REQ-032 The fine code SHALL saturate at 0 and at 2^FINE_W-1 without wrap-around; a clamp SHALL set fine_sat.
REQ-033 When the in-band counter reaches LOCK_CNT, locked SHALL rise on the same edge and the state SHALL become LOCKED.
REQ-034 In LOCKED, tracking SHALL continue with the REQ-030 step rule.
REQ-035 In LOCKED, |err|>UNLOCK_TOL SHALL clear locked and the in-band counter and return to FINE_TRACK.
REQ-036 Every measurement SHALL be preceded by SETTLE, including measurements made with no code change.
REQ-037 enable=0 in any state SHALL go to IDLE on the next edge and clear locked; the codes SHALL hold their last values.
REQ-038 Arithmetic SHALL compare the full ERR_W signed value against the tolerances, sign-extended; the -2^(ERR_W-1) case SHALL count as out-of-band.
REQ-039 If meas_valid coincides with the timeout cycle, meas_valid SHALL take priority.

Reset
REQ-040 On reset, all outputs SHALL be driven to 0, the state to IDLE, and all counters and sticky flags cleared.
REQ-041 Sticky flags SHALL also clear on the IDLE-to-SETTLE transition.
REQ-042 Reset asserted mid-search SHALL abort immediately; no meas_start SHALL be issued while reset is high.

Structure
REQ-043 Package dco_tune_pkg SHALL hold the state enum typedef and the default parameter constants.
REQ-044 One sub-module, dco_settle_timer, SHALL be a shared down-counter serving both SETTLE and the MEAS timeout.

Verification
REQ-045 Coarse search: target at coarse=37 (model err=+5 while code<37, -5 while code>37) -> sw_coarse=37 after 6 measurements, then FINE_TRACK.
REQ-046 Lock: constant err=1 -> locked=1 after the 4th fine measurement; sw_fine=128 unchanged.
REQ-047 Unlock: from LOCKED, single err=9 -> locked=0, sw_fine=129, state FINE_TRACK; err=8 keeps locked=1.
REQ-048 Saturation: err=+100 indefinitely -> sw_fine climbs to 255 and holds; fine_sat=1; no wrap to 0.
REQ-049 Timeout: suppress meas_valid -> timeout_err=1 at cycle 1024 in MEAS, state IDLE, busy=0.
REQ-050 Mid-operation abort: reset pulse during coarse bit 3 -> all outputs 0 asynchronously; enable=0 -> IDLE next edge with codes held.

Source files
------------

// File: rtl/dco_tune_pkg.sv
// Shared types and default constants for the DCO tuning controller.
package dco_tune_pkg;

    localparam int DEF_COARSE_W    = 6;
    localparam int DEF_FINE_W      = 8;
    localparam int DEF_ERR_W       = 16;
    localparam int DEF_SETTLE_CYC  = 8;
    localparam int DEF_LOCK_TOL    = 2;
    localparam int DEF_UNLOCK_TOL  = 8;
    localparam int DEF_LOCK_CNT    = 4;
    localparam int DEF_TIMEOUT_CYC = 1024;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SETTLE     = 3'd1,
        MEAS       = 3'd2,
        COARSE_UPD = 3'd3,
        FINE_TRACK = 3'd4,
        LOCKED     = 3'd5
    } dco_state_t;

    // The shared timer must be wide enough for the longer of the two waits.
    function automatic int timer_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/dco_tune_ctrl_if.sv
// Measurement handshake, DCO code and status bundle of the tuning controller.
interface dco_tune_ctrl_if
    import dco_tune_pkg::*;
#(
    parameter int COARSE_W = DEF_COARSE_W,
    parameter int FINE_W   = DEF_FINE_W,
    parameter int ERR_W    = DEF_ERR_W
) ();

    logic                       enable;
    logic                       meas_start;
    logic                       meas_valid;
    logic signed [ERR_W-1:0]    meas_err;
    logic [COARSE_W-1:0]        sw_coarse;
    logic [FINE_W-1:0]          sw_fine;
    logic                       locked;
    logic                       busy;
    logic                       fine_sat;
    logic                       timeout_err;

    modport master (
        input  enable, meas_valid, meas_err,
        output meas_start, sw_coarse, sw_fine, locked, busy, fine_sat, timeout_err
    );

    modport slave (
        output enable, meas_valid, meas_err,
        input  meas_start, sw_coarse, sw_fine, locked, busy, fine_sat, timeout_err
    );

endinterface

// File: rtl/dco_settle_timer.sv
// Down-counter shared by the settle wait and the measurement timeout.
module dco_settle_timer #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count_reg;

    // Load on request, otherwise count down and park at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign expired = (count_reg == '0);

endmodule

// File: rtl/dco_tune_ctrl.sv
// DCO tuning controller: binary search on the coarse bank, then fine tracking with lock detect.
module dco_tune_ctrl
    import dco_tune_pkg::*;
#(
    parameter int COARSE_W    = DEF_COARSE_W,
    parameter int FINE_W      = DEF_FINE_W,
    parameter int ERR_W       = DEF_ERR_W,
    parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int LOCK_TOL    = DEF_LOCK_TOL,
    parameter int UNLOCK_TOL  = DEF_UNLOCK_TOL,
    parameter int LOCK_CNT    = DEF_LOCK_CNT,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic            ref_clk,
    input  logic            reset,
    dco_tune_ctrl_if.master bus
);

    localparam int TW    = timer_width(SETTLE_CYC, TIMEOUT_CYC);
    localparam int BW    = $clog2(COARSE_W);
    localparam int CNT_W = $clog2(LOCK_CNT + 1);

    localparam logic [TW-1:0]       SETTLE_LOAD  = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0]       TIMEOUT_LOAD = TW'(TIMEOUT_CYC - 1);
    localparam logic [COARSE_W-1:0] COARSE_MID   = {1'b1, {(COARSE_W-1){1'b0}}};
    localparam logic [FINE_W-1:0]   FINE_MID     = {1'b1, {(FINE_W-1){1'b0}}};
    localparam logic [FINE_W-1:0]   FINE_MAX     = '1;
    localparam logic [CNT_W-1:0]    LOCK_CNT_V   = CNT_W'(LOCK_CNT);
    // Tolerances one bit wider than the error so the most negative error stays out-of-band.
    localparam logic signed [ERR_W:0] TOL_HI   = (ERR_W+1)'(LOCK_TOL);
    localparam logic signed [ERR_W:0] TOL_LO   = (ERR_W+1)'(-LOCK_TOL);
    localparam logic signed [ERR_W:0] UTOL_HI  = (ERR_W+1)'(UNLOCK_TOL);
    localparam logic signed [ERR_W:0] UTOL_LO  = (ERR_W+1)'(-UNLOCK_TOL);

    dco_state_t          state_reg, state_next;
    logic [COARSE_W-1:0] coarse_reg, coarse_next;
    logic [FINE_W-1:0]   fine_reg, fine_next;
    logic [BW-1:0]       bit_reg, bit_next;
    logic                coarse_done_reg, coarse_done_next;
    logic [CNT_W-1:0]    inband_reg, inband_next;
    logic                locked_reg, locked_next;
    logic                fine_sat_reg, fine_sat_next;
    logic                timeout_reg, timeout_next;
    logic                meas_start_reg, meas_start_next;

    logic                timer_load;
    logic [TW-1:0]       timer_val;
    logic                timer_zero;

    logic signed [ERR_W:0] err_x;
    logic                  err_hi, err_lo, err_big;

    assign err_x   = {bus.meas_err[ERR_W-1], bus.meas_err};
    assign err_hi  = (err_x > TOL_HI);
    assign err_lo  = (err_x < TOL_LO);
    assign err_big = (err_x > UTOL_HI) || (err_x < UTOL_LO);

    dco_settle_timer #(.W(TW)) u_timer (
        .clk      (ref_clk),
        .rst      (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .expired  (timer_zero)
    );

    // Next-state, code update and timer control.
    always_comb begin
        state_next       = state_reg;
        coarse_next      = coarse_reg;
        fine_next        = fine_reg;
        bit_next         = bit_reg;
        coarse_done_next = coarse_done_reg;
        inband_next      = inband_reg;
        locked_next      = locked_reg;
        fine_sat_next    = fine_sat_reg;
        timeout_next     = timeout_reg;
        meas_start_next  = 1'b0;
        timer_load       = 1'b0;
        timer_val        = '0;

        if (!bus.enable) begin
            // Abort: codes keep their last values, only lock is dropped.
            state_next  = IDLE;
            locked_next = 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    coarse_next      = COARSE_MID;
                    fine_next        = FINE_MID;
                    bit_next         = BW'(COARSE_W - 1);
                    coarse_done_next = 1'b0;
                    inband_next      = '0;
                    locked_next      = 1'b0;
                    fine_sat_next    = 1'b0;
                    timeout_next     = 1'b0;
                    state_next       = SETTLE;
                    timer_load       = 1'b1;
                    timer_val        = SETTLE_LOAD;
                end
                SETTLE: begin
                    if (timer_zero) begin
                        state_next      = MEAS;
                        meas_start_next = 1'b1;
                        timer_load      = 1'b1;
                        timer_val       = TIMEOUT_LOAD;
                    end
                end
                MEAS: begin
                    if (bus.meas_valid) begin
                        if (!coarse_done_reg) begin
                            // Negative error: DCO too slow, so this capacitor bit comes out.
                            if (bus.meas_err[ERR_W-1]) coarse_next[bit_reg] = 1'b0;
                            if (bit_reg == '0) begin
                                coarse_done_next = 1'b1;
                            end else begin
                                bit_next = bit_reg - 1'b1;
                                coarse_next[bit_reg - 1'b1] = 1'b1;
                            end
                            state_next = COARSE_UPD;
                        end else begin
                            if (err_hi) begin
                                if (fine_reg == FINE_MAX) fine_sat_next = 1'b1;
                                else                      fine_next = fine_reg + 1'b1;
                            end else if (err_lo) begin
                                if (fine_reg == '0) fine_sat_next = 1'b1;
                                else                fine_next = fine_reg - 1'b1;
                            end
                            if (err_hi || err_lo)            inband_next = '0;
                            else if (inband_reg != LOCK_CNT_V) inband_next = inband_reg + 1'b1;

                            if (locked_reg) begin
                                if (err_big) begin
                                    locked_next = 1'b0;
                                    inband_next = '0;
                                    state_next  = FINE_TRACK;
                                end else begin
                                    state_next  = LOCKED;
                                end
                            end else if (inband_next == LOCK_CNT_V) begin
                                locked_next = 1'b1;
                                state_next  = LOCKED;
                            end else begin
                                state_next  = FINE_TRACK;
                            end
                        end
                    end else if (timer_zero) begin
                        timeout_next = 1'b1;
                        locked_next  = 1'b0;
                        state_next   = IDLE;
                    end
                end
                COARSE_UPD, FINE_TRACK, LOCKED: begin
                    // Every measurement, changed code or not, gets a fresh settle wait.
                    state_next = SETTLE;
                    timer_load = 1'b1;
                    timer_val  = SETTLE_LOAD;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            coarse_reg      <= '0;
            fine_reg        <= '0;
            bit_reg         <= '0;
            coarse_done_reg <= 1'b0;
            inband_reg      <= '0;
            locked_reg      <= 1'b0;
            fine_sat_reg    <= 1'b0;
            timeout_reg     <= 1'b0;
            meas_start_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            coarse_reg      <= coarse_next;
            fine_reg        <= fine_next;
            bit_reg         <= bit_next;
            coarse_done_reg <= coarse_done_next;
            inband_reg      <= inband_next;
            locked_reg      <= locked_next;
            fine_sat_reg    <= fine_sat_next;
            timeout_reg     <= timeout_next;
            meas_start_reg  <= meas_start_next;
        end
    end

    assign bus.meas_start  = meas_start_reg;
    assign bus.sw_coarse   = coarse_reg;
    assign bus.sw_fine     = fine_reg;
    assign bus.locked      = locked_reg;
    assign bus.busy        = (state_reg != IDLE);
    assign bus.fine_sat    = fine_sat_reg;
    assign bus.timeout_err = timeout_reg;

endmodule

// File: tb/tb_dco_tune_ctrl.sv
// Randomized self-checking bench for dco_tune_ctrl against a transaction-level tuning model.
module tb_dco_tune_ctrl;
    import dco_tune_pkg::*;

    localparam int CW = 6;
    localparam int FW = 8;
    localparam int EW = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dco_tune_ctrl_if #(.COARSE_W(CW), .FINE_W(FW), .ERR_W(EW)) bus ();

    dco_tune_ctrl #(.COARSE_W(CW), .FINE_W(FW), .ERR_W(EW)) dut (
        .ref_clk (clk),
        .reset   (rst),
        .bus     (bus.master)
    );

    int total = 0;
    int bad   = 0;
    int meas_no = 0;

    // Reference model: binary search expressed as base + trial weight, fine code as a clamped integer.
    int m_base, m_weight, m_coarse, m_fine, m_cnt;
    bit m_fine_phase, m_locked, m_sat;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_start();
        m_base = 0; m_weight = 32; m_coarse = 32; m_fine = 128;
        m_cnt = 0; m_fine_phase = 0; m_locked = 0; m_sat = 0;
    endtask

    task automatic model_apply(input int e);
        if (!m_fine_phase) begin
            if (e >= 0) m_base = m_base + m_weight;
            m_weight = m_weight / 2;
            if (m_weight == 0) begin
                m_coarse = m_base;
                m_fine_phase = 1;
            end else begin
                m_coarse = m_base + m_weight;
            end
        end else begin
            if (e > 2) begin
                if (m_fine == 255) m_sat = 1; else m_fine = m_fine + 1;
            end else if (e < -2) begin
                if (m_fine == 0) m_sat = 1; else m_fine = m_fine - 1;
            end
            if (e >= -2 && e <= 2) m_cnt = m_cnt + 1; else m_cnt = 0;
            if (m_locked) begin
                if (e > 8 || e < -8) begin m_locked = 0; m_cnt = 0; end
            end else if (m_cnt >= 4) begin
                m_locked = 1;
            end
        end
    endtask

    function automatic int coarse_err(input int target);
        if (m_coarse < target) return 5;
        if (m_coarse > target) return -5;
        return 0;
    endfunction

    function automatic int rand_err();
        int r;
        logic signed [15:0] v;
        r = int'($urandom_range(0, 9));
        if (r <= 4) return int'($urandom_range(0, 6)) - 3;
        if (r <= 6) return (($urandom_range(0, 1) == 1) ? 1 : -1) * int'($urandom_range(3, 12));
        if (r == 7) begin v = 16'($urandom); return int'(v); end
        if (r == 8) return -32768;
        return 32767;
    endfunction

    // One measurement transaction: wait for the request, answer after dly cycles, check the result.
    task automatic run_meas(input int e, input int dly);
        int n;
        n = 0;
        while (bus.meas_start !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (bus.meas_start !== 1'b1) begin
            check_val("meas_start_wait", 32'(bus.meas_start), 32'd1);
            return;
        end
        for (int i = 0; i < dly; i++) begin
            @(posedge clk); #1;
        end
        bus.meas_valid = 1'b1;
        bus.meas_err   = 16'(e);
        @(posedge clk); #1;
        bus.meas_valid = 1'b0;
        bus.meas_err   = 16'($urandom);
        model_apply(e);
        meas_no++;
        $display("meas %0d: err=%0d dly=%0d coarse=%0d fine=%0d locked=%0b sat=%0b",
                 meas_no, e, dly, bus.sw_coarse, bus.sw_fine, bus.locked, bus.fine_sat);
        check_val("meas_coarse", 32'(bus.sw_coarse), 32'(m_coarse));
        check_val("meas_fine",   32'(bus.sw_fine),   32'(m_fine));
        check_val("meas_locked", 32'(bus.locked),    32'(m_locked));
        check_val("meas_sat",    32'(bus.fine_sat),  32'(m_sat));
    endtask

    // Pulse meas_valid while the controller is settling; it must have no effect.
    task automatic spurious_valid();
        @(posedge clk); #1;
        bus.meas_valid = 1'b1;
        bus.meas_err   = 16'sd32767;
        @(posedge clk); #1;
        bus.meas_valid = 1'b0;
    endtask

    task automatic enable_abort_check();
        bus.enable = 1'b0;
        @(posedge clk); #1;
        m_locked = 0;
        check_val("abort_busy",   32'(bus.busy),      32'd0);
        check_val("abort_locked", 32'(bus.locked),    32'd0);
        check_val("abort_coarse", 32'(bus.sw_coarse), 32'(m_coarse));
        check_val("abort_fine",   32'(bus.sw_fine),   32'(m_fine));
        check_val("abort_state",  32'(dut.state_reg), 32'(IDLE));
    endtask

    task automatic start_run();
        model_start();
        bus.enable = 1'b1;
        @(posedge clk); #1;
        check_val("start_busy",   32'(bus.busy),        32'd1);
        check_val("start_coarse", 32'(bus.sw_coarse),   32'd32);
        check_val("start_fine",   32'(bus.sw_fine),     32'd128);
        check_val("start_sat",    32'(bus.fine_sat),    32'd0);
        check_val("start_tmo",    32'(bus.timeout_err), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus.enable = 1'b0;
        bus.meas_valid = 1'b0;
        bus.meas_err = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_coarse", 32'(bus.sw_coarse),   32'd0);
        check_val("rst_fine",   32'(bus.sw_fine),     32'd0);
        check_val("rst_locked", 32'(bus.locked),      32'd0);
        check_val("rst_busy",   32'(bus.busy),        32'd0);
        check_val("rst_start",  32'(bus.meas_start),  32'd0);
        check_val("rst_tmo",    32'(bus.timeout_err), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Coarse search toward 37, then lock with a constant small error.
        start_run();
        for (int i = 0; i < 6; i++) run_meas(coarse_err(37), int'($urandom_range(0, 4)));
        check_val("coarse_37", 32'(bus.sw_coarse), 32'd37);
        for (int i = 0; i < 4; i++) begin
            run_meas(1, int'($urandom_range(0, 4)));
            if (i == 0) check_val("fine_track_state", 32'(dut.state_reg), 32'(FINE_TRACK));
            if (i == 2) check_val("no_early_lock", 32'(bus.locked), 32'd0);
        end
        check_val("lock_4th",    32'(bus.locked),    32'd1);
        check_val("lock_fine",   32'(bus.sw_fine),   32'd128);
        check_val("lock_state",  32'(dut.state_reg), 32'(LOCKED));
        run_meas(9, 1);
        check_val("unlock_9",       32'(bus.locked),    32'd0);
        check_val("unlock_fine",    32'(bus.sw_fine),   32'd129);
        check_val("unlock_state",   32'(dut.state_reg), 32'(FINE_TRACK));
        for (int i = 0; i < 4; i++) run_meas(0, 0);
        run_meas(8, 2);
        check_val("keep_lock_8", 32'(bus.locked),  32'd1);
        check_val("keep_fine_8", 32'(bus.sw_fine), 32'd130);

        // Randomized tracking with occasional stray meas_valid pulses.
        for (int i = 0; i < 150; i++) begin
            run_meas(rand_err(), int'($urandom_range(0, 6)));
            if ($urandom_range(0, 3) == 0) spurious_valid();
        end
        enable_abort_check();

        // Saturation at the top of the fine range.
        start_run();
        for (int i = 0; i < 6; i++) run_meas(100, 0);
        check_val("sat_coarse", 32'(bus.sw_coarse), 32'd63);
        for (int i = 0; i < 130; i++) run_meas(100, int'($urandom_range(0, 2)));
        check_val("sat_fine_max", 32'(bus.sw_fine),  32'd255);
        check_val("sat_flag",     32'(bus.fine_sat), 32'd1);
        bus.enable = 1'b0;
        @(posedge clk); #1;

        // meas_valid on the last allowed MEAS cycle wins over the timeout.
        start_run();
        run_meas(coarse_err(20), 1023);
        check_val("prio_no_tmo", 32'(bus.timeout_err), 32'd0);
        check_val("prio_busy",   32'(bus.busy),        32'd1);

        // Timeout with no response at all.
        n = 0;
        while (bus.meas_start !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        check_val("tmo_meas_start", 32'(bus.meas_start), 32'd1);
        for (int i = 0; i < 1023; i++) begin @(posedge clk); #1; end
        check_val("tmo_not_yet", 32'(bus.timeout_err), 32'd0);
        check_val("tmo_busy_1023", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        check_val("tmo_flag",   32'(bus.timeout_err), 32'd1);
        check_val("tmo_busy",   32'(bus.busy),        32'd0);
        check_val("tmo_state",  32'(dut.state_reg),   32'(IDLE));
        bus.enable = 1'b0;
        @(posedge clk); #1;
        check_val("tmo_sticky", 32'(bus.timeout_err), 32'd1);

        // Asynchronous reset in the middle of the coarse bit-3 measurement.
        start_run();
        run_meas(coarse_err(50), 0);
        run_meas(coarse_err(50), 0);
        n = 0;
        while (bus.meas_start !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        #2 rst = 1'b1;
        #1;
        check_val("arst_coarse", 32'(bus.sw_coarse),   32'd0);
        check_val("arst_fine",   32'(bus.sw_fine),     32'd0);
        check_val("arst_busy",   32'(bus.busy),        32'd0);
        check_val("arst_start",  32'(bus.meas_start),  32'd0);
        check_val("arst_locked", 32'(bus.locked),      32'd0);
        check_val("arst_sat",    32'(bus.fine_sat),    32'd0);
        check_val("arst_tmo",    32'(bus.timeout_err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_val("arst_hold_start", 32'(bus.meas_start), 32'd0);
            check_val("arst_hold_busy",  32'(bus.busy),       32'd0);
        end
        rst = 1'b0;
        model_start();
        for (int i = 0; i < 3; i++) run_meas(coarse_err(21), int'($urandom_range(0, 3)));
        enable_abort_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: sim time expired, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
